// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: FSM encoding and ALU opcode constants.
// Latency: none (declarations only). Backpressure: not applicable.
// Optional build macro: ALU_ARB_FIXED_PRIORITY_EN (consumed by rr_picker and alu_arbiter).
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

endpackage

// File: rtl/rr_picker.sv
// Picks one requester: first valid at or after ptr (round-robin), or lowest index with ALU_ARB_FIXED_PRIORITY_EN.
// Latency: purely combinational. Backpressure: none; the caller decides when a pick is consumed.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    logic [IDX_W-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'(k);
      if (req[cand] && !any) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end
`else
  always_comb begin
    logic [IDX_W-1:0] cand;
    int               j;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    j    = 0;
    // scan N slots starting at ptr, wrapping past the top index
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      cand = IDX_W'(j);
      if (req[cand] && !any) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters; round-robin unless ALU_ARB_FIXED_PRIORITY_EN is defined.
// Latency: request handshake at edge T -> RespValid from edge T+2; one operation per 4 cycles at best.
// Backpressure: ReqReady only in IDLE; response held until RespReady of the granted requester.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 16,
  parameter int OP_W    = 3
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [NUM_REQ-1:0]       ReqValid,
  output logic [NUM_REQ-1:0]       ReqReady,
  input  logic [NUM_REQ*WIDTH-1:0] ReqFirst,
  input  logic [NUM_REQ*WIDTH-1:0] ReqSecond,
  input  logic [NUM_REQ*OP_W-1:0]  ReqOp,
  output logic [NUM_REQ-1:0]       RespValid,
  input  logic [NUM_REQ-1:0]       RespReady,
  output logic [WIDTH-1:0]         RespData,
  output logic                     RespZero,
  output logic [WIDTH-1:0]         AluFirst,
  output logic [WIDTH-1:0]         AluSecond,
  output logic [OP_W-1:0]          AluOp,
  input  logic [WIDTH-1:0]         AluResult,
  input  logic                     AluZero,
  output logic                     Busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr_q, gnt_q, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any;

  logic [WIDTH-1:0] first_arr  [NUM_REQ];
  logic [WIDTH-1:0] second_arr [NUM_REQ];
  logic [OP_W-1:0]  op_arr     [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign first_arr[i]  = ReqFirst[i*WIDTH +: WIDTH];
    assign second_arr[i] = ReqSecond[i*WIDTH +: WIDTH];
    assign op_arr[i]     = ReqOp[i*OP_W +: OP_W];
  end

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req (ReqValid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (pick_any) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP:    if (RespReady[gnt_q]) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ReqReady = (state == ST_IDLE) ? pick_gnt : '0;
    Busy     = (state != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      AluFirst  <= '0;
      AluSecond <= '0;
      AluOp     <= '0;
      RespValid <= '0;
      RespData  <= '0;
      RespZero  <= 1'b0;
      gnt_q     <= '0;
      ptr_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            AluFirst  <= first_arr[pick_idx];
            AluSecond <= second_arr[pick_idx];
            AluOp     <= op_arr[pick_idx];
            gnt_q     <= pick_idx;
          end
        end
        ST_CAPTURE: begin
          // ALU output now reflects the operands issued two edges ago
          RespData         <= AluResult;
          RespZero         <= AluZero;
          RespValid        <= '0;
          RespValid[gnt_q] <= 1'b1;
          AluFirst         <= '0;
          AluSecond        <= '0;
          AluOp            <= '0;
        end
        ST_RESP: begin
          if (RespReady[gnt_q]) begin
            RespValid <= '0;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            ptr_q <= '0;
`else
            ptr_q <= (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered ALU model; expectations follow ALU_ARB_FIXED_PRIORITY_EN when defined.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [1:0]  ReqValid = '0;
  logic [1:0]  ReqReady;
  logic [31:0] ReqFirst = '0;
  logic [31:0] ReqSecond = '0;
  logic [5:0]  ReqOp = '0;
  logic [1:0]  RespValid;
  logic [1:0]  RespReady = '0;
  logic [15:0] RespData;
  logic        RespZero;
  logic [15:0] AluFirst, AluSecond;
  logic [2:0]  AluOp;
  logic [15:0] AluResult = '0;
  logic        AluZero = 1'b0;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.NUM_REQ(2), .WIDTH(16), .OP_W(3)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqFirst(ReqFirst), .ReqSecond(ReqSecond), .ReqOp(ReqOp),
    .RespValid(RespValid), .RespReady(RespReady),
    .RespData(RespData), .RespZero(RespZero),
    .AluFirst(AluFirst), .AluSecond(AluSecond), .AluOp(AluOp),
    .AluResult(AluResult), .AluZero(AluZero), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // registered ALU: samples its inputs at each rising edge
  always @(posedge CLK) begin
    case (AluOp)
      ALU_ADD: AluResult <= AluFirst + AluSecond;
      ALU_SUB: AluResult <= AluFirst - AluSecond;
      ALU_OR:  AluResult <= AluFirst | AluSecond;
      ALU_AND: AluResult <= AluFirst & AluSecond;
      ALU_SHL: AluResult <= AluFirst << AluSecond[3:0];
      ALU_SHR: AluResult <= AluFirst >> AluSecond[3:0];
      ALU_XOR: AluResult <= AluFirst ^ AluSecond;
      default: AluResult <= '0;
    endcase
    AluZero <= ((AluFirst - AluSecond) == 16'd0) || (AluOp == ALU_NOP);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    @(negedge CLK);
    RESET_N   = 1'b0;
    ReqValid  = '0;
    RespReady = '0;
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic set_slot(input int s, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    ReqFirst[s*16 +: 16]  = a;
    ReqSecond[s*16 +: 16] = b;
    ReqOp[s*3 +: 3]       = op;
  endtask

  // waits (bounded) for a grant; returns the ReqReady vector seen, leaves the bench just past the handshake edge
  task automatic wait_grant(output logic [1:0] g, output bit timeout);
    g = '0;
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ReqReady != 2'b00) begin
        g = ReqReady;
        timeout = 1'b0;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (RespValid !== 2'b00) begin errors++; $display("FAIL reset_respvalid got=%b exp=00", RespValid); end
    checks++; if (RespData !== 16'h0 || RespZero !== 1'b0) begin errors++; $display("FAIL reset_resp got=%h/%b exp=0000/0", RespData, RespZero); end
    checks++; if (AluFirst !== 16'h0 || AluSecond !== 16'h0 || AluOp !== 3'd0) begin errors++; $display("FAIL reset_alu got=%h %h %h exp=0 0 0", AluFirst, AluSecond, AluOp); end
    checks++; if (ReqReady !== 2'b00) begin errors++; $display("FAIL reset_reqready got=%b exp=00", ReqReady); end
  endtask

  task automatic test_add;
    do_reset();
    set_slot(0, 16'd3, 16'd4, ALU_ADD);
    ReqValid = 2'b01;
    #1;
    checks++; if (ReqReady !== 2'b01) begin errors++; $display("FAIL add_reqready got=%b exp=01", ReqReady); end
    tick();
    ReqValid = 2'b00;
    #1;
    checks++; if (ReqReady !== 2'b00 || Busy !== 1'b1) begin errors++; $display("FAIL add_issue_ready_busy got=%b/%b exp=00/1", ReqReady, Busy); end
    checks++; if (AluOp !== ALU_ADD || AluFirst !== 16'd3 || AluSecond !== 16'd4) begin errors++; $display("FAIL add_alu_in got=%h %h %h exp=3 4 1", AluFirst, AluSecond, AluOp); end
    tick();
    checks++; if (RespValid !== 2'b00) begin errors++; $display("FAIL add_capture_vld got=%b exp=00", RespValid); end
    tick();
    checks++; if (RespValid !== 2'b01) begin errors++; $display("FAIL add_resp_vld got=%b exp=01", RespValid); end
    checks++; if (RespData !== 16'd7 || RespZero !== 1'b0) begin errors++; $display("FAIL add_resp_data got=%h/%b exp=0007/0", RespData, RespZero); end
    checks++; if (AluOp !== 3'd0 || AluFirst !== 16'd0) begin errors++; $display("FAIL add_alu_nop got=%h/%h exp=0/0", AluOp, AluFirst); end
    RespReady = 2'b01;
    tick();
    RespReady = 2'b00;
    checks++; if (RespValid !== 2'b00 || Busy !== 1'b0) begin errors++; $display("FAIL add_release got=%b/%b exp=00/0", RespValid, Busy); end
  endtask

  task automatic test_sub_zero;
    logic [1:0] g;
    bit to;
    do_reset();
    set_slot(1, 16'd5, 16'd5, ALU_SUB);
    ReqValid = 2'b10;
    #1;
    wait_grant(g, to);
    ReqValid = 2'b00;
    checks++; if (to || g !== 2'b10) begin errors++; $display("FAIL sub_grant got=%b timeout=%0d exp=10", g, to); end
    tick();
    tick();
    checks++; if (RespValid !== 2'b10) begin errors++; $display("FAIL sub_resp_vld got=%b exp=10", RespValid); end
    checks++; if (RespData !== 16'd0 || RespZero !== 1'b1) begin errors++; $display("FAIL sub_resp_data got=%h/%b exp=0000/1", RespData, RespZero); end
    RespReady = 2'b10;
    tick();
    RespReady = 2'b00;
    checks++; if (RespValid !== 2'b00) begin errors++; $display("FAIL sub_release got=%b exp=00", RespValid); end
  endtask

  task automatic test_round_robin;
    logic [1:0]  g, exp_g;
    logic [15:0] exp_d;
    bit to;
    do_reset();
    set_slot(0, 16'd10, 16'd20, ALU_ADD);
    set_slot(1, 16'h00FF, 16'h0F0F, ALU_XOR);
    ReqValid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      exp_d = (exp_g == 2'b01) ? 16'd30 : 16'h0FF0;
      wait_grant(g, to);
      checks++; if (to || g !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got=%b timeout=%0d exp=%b", i, g, to, exp_g); end
      tick();
      tick();
      checks++; if (RespValid !== exp_g || RespData !== exp_d || RespZero !== 1'b0) begin
        errors++; $display("FAIL rr_resp[%0d] got=%b/%h/%b exp=%b/%h/0", i, RespValid, RespData, RespZero, exp_g, exp_d);
      end
      RespReady = 2'b11;
      tick();
      RespReady = 2'b00;
    end
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    ReqValid = 2'b10;
    #1;
    wait_grant(g, to);
    checks++; if (to || g !== 2'b10) begin errors++; $display("FAIL fixed_grant1 got=%b timeout=%0d exp=10", g, to); end
    tick();
    tick();
    RespReady = 2'b10;
    tick();
    RespReady = 2'b00;
`endif
    ReqValid = 2'b00;
  endtask

  task automatic test_stall;
    logic [1:0] g, exp_g;
    bit to;
    int bad;
    do_reset();
    set_slot(0, 16'd9, 16'd2, ALU_SUB);
    set_slot(1, 16'hF0F0, 16'hFF00, ALU_AND);
    ReqValid = 2'b11;
    #1;
    wait_grant(g, to);
    checks++; if (to || g !== 2'b01) begin errors++; $display("FAIL stall_grant0 got=%b timeout=%0d exp=01", g, to); end
    tick();
    tick();
    checks++; if (RespValid !== 2'b01 || RespData !== 16'd7) begin errors++; $display("FAIL stall_resp got=%b/%h exp=01/0007", RespValid, RespData); end
    RespReady = 2'b10;  // other requester's ready must not release the response
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (RespValid !== 2'b01 || RespData !== 16'd7 || RespZero !== 1'b0 || Busy !== 1'b1 || ReqReady !== 2'b00) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
    RespReady = 2'b01;
    tick();
    RespReady = 2'b00;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    exp_g = 2'b01;
`else
    exp_g = 2'b10;
`endif
    checks++; if (ReqReady !== exp_g) begin errors++; $display("FAIL stall_next_grant got=%b exp=%b", ReqReady, exp_g); end
    wait_grant(g, to);
    ReqValid = 2'b00;
    tick();
    tick();
    checks++; if (RespValid !== exp_g || RespData !== ((exp_g == 2'b10) ? 16'hF000 : 16'd7)) begin
      errors++; $display("FAIL stall_next_resp got=%b/%h exp=%b", RespValid, RespData, exp_g);
    end
    RespReady = 2'b11;
    tick();
    RespReady = 2'b00;
  endtask

  task automatic test_reset_mid_op;
    logic [1:0] g;
    bit to;
    int seen;
    do_reset();
    set_slot(1, 16'd1, 16'd1, ALU_ADD);
    ReqValid = 2'b10;
    #1;
    wait_grant(g, to);
    ReqValid = 2'b00;
    checks++; if (to || Busy !== 1'b1 || AluOp !== ALU_ADD) begin errors++; $display("FAIL mid_issue got busy=%b op=%h exp=1/1", Busy, AluOp); end
    #2;
    RESET_N = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0 || AluOp !== 3'd0 || AluFirst !== 16'd0 || RespValid !== 2'b00 || ReqReady !== 2'b00) begin
      errors++; $display("FAIL mid_async_clear got=%b %h %h %b %b exp=0 0 0 00 00", Busy, AluOp, AluFirst, RespValid, ReqReady);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (RespValid !== 2'b00) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_resp got=%0d cycles exp=0", seen); end
    ReqValid = 2'b11;
    #1;
    checks++; if (ReqReady !== 2'b01) begin errors++; $display("FAIL mid_first_grant got=%b exp=01", ReqReady); end
    ReqValid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_round_robin();
    test_stall();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
